mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multicycle MIPS main control FSM; the producer side of the aluop interface that alu_control decodes.
- Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j and addi, plus slti when the optional feature is compiled in.
- Drives datapath mux selects and write enables.
- Waits on a memory ready handshake, with a watchdog timeout.

Parameters:
- TIMEOUT, 15: max consecutive cycles a wait state tolerates memready=0. 0 disables the watchdog. Legal range 0..255.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  6  opcode from instruction register, stable from DECODE onward
- memready  input  1  memory access complete this cycle
- pcwrite  output  1  unconditional PC write
- pcwritecond  output  1  PC write if ALU zero
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- irwrite  output  1  instruction register load
- memtoreg  output  1  writeback select: 1=MDR, 0=ALUOut
- regdst  output  1  destination select: 1=rd, 0=rt
- regwrite  output  1  register file write
- alusrca  output  1  ALU A select: 0=PC, 1=rs
- alusrcb  output  2  ALU B select: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2
- pcsource  output  2  PC next select: 00=ALU, 01=ALUOut, 10=jump target
- aluop  output  2  to alu_control: 00 add, 01 sub, 10 funct, 11 slt
- state  output  4  current state, for debug
- illegal  output  1  one-cycle pulse on unsupported opcode
- buserr  output  1  one-cycle pulse on memory timeout

Behaviour:
- State register resets asynchronously to FETCH (0). Reset values: illegal=0, buserr=0, wait counter=0.
- All other outputs are combinational from state; at reset they take the FETCH values. Any output not listed for a state is 0.
- States, outputs and transitions:
  - FETCH(0): memread=1, alusrcb=01, aluop=00. irwrite=1 and pcwrite=1 only in the cycle memready=1. Stay while memready=0; go to DECODE on memready=1.
  - DECODE(1): alusrcb=11, aluop=00. Opcode dispatch:
    - 000000 -> EXECUTE
    - 100011 or 101011 -> MEMADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> IMM_EX
    - any other opcode -> FETCH with illegal pulsed the next cycle
  - MEMADDR(2): alusrca=1, alusrcb=10, aluop=00. Go to MEMREAD if op=100011, else MEMWRITE.
  - MEMREAD(3): memread=1, iord=1. Wait for memready, then MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0. Then FETCH.
  - MEMWRITE(5): memwrite=1, iord=1. Wait for memready, then FETCH.
  - EXECUTE(6): alusrca=1, alusrcb=00, aluop=10. Then RTYPE_WB.
  - RTYPE_WB(7): regwrite=1, regdst=1. Then FETCH.
  - BRANCH(8): alusrca=1, aluop=01, pcwritecond=1, pcsource=01. Then FETCH.
  - JUMP(9): pcwrite=1, pcsource=10. Then FETCH.
  - IMM_EX(10): alusrca=1, alusrcb=10, aluop=00 for addi. Then IMM_WB.
  - IMM_WB(11): regwrite=1, regdst=0, memtoreg=0. Then FETCH.
  - Codes 12-15 are unreachable; if entered, go to FETCH.
- Latency with memready=1 throughout: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Watchdog, wait states FETCH/MEMREAD/MEMWRITE only:
  - 8-bit counter increments each cycle the FSM is in a wait state with memready=0. It clears on memready=1 or on leaving the wait state.
  - When the counter reaches TIMEOUT with memready still 0, next state is FETCH and buserr pulses the next cycle; the counter clears.
  - A timeout in FETCH restarts the fetch.
  - memready=1 in the same cycle as the count reaching TIMEOUT: memready wins, no buserr.
- illegal and buserr are registered, high for exactly one cycle.
- rst_n asserted mid-instruction: immediate return to FETCH, with pulses and counter cleared.
- memready outside wait states is ignored.

Optional Feature:
- MC_SLTI_EN defined: opcode 001010 in DECODE -> IMM_EX. IMM_EX drives aluop=11 when op=001010, 00 otherwise. slti latency is 4 cycles.
- MC_SLTI_EN undefined: 001010 is illegal (FETCH plus illegal pulse); IMM_EX always drives aluop=00.

Test Plan:
- Reset low, memready=1, release; R-type op=000000 -> states 0,1,6,7,0. aluop=10 in state 6, regwrite=1 and regdst=1 in state 7.
- lw op=100011, memready low for 3 cycles in MEMREAD, TIMEOUT=15 -> FSM holds in state 3 for 4 cycles, then state 4 with memtoreg=1, no buserr.
- sw op=101011, memready held low, TIMEOUT=4 -> after 4 low cycles in state 5, FSM goes to FETCH and buserr is high for exactly 1 cycle. memwrite=1 throughout state 5.
- beq op=000100 then j op=000010 -> state 8 with pcwritecond=1, pcsource=01, aluop=01; state 9 with pcwrite=1, pcsource=10. Each instruction takes 3 cycles.
- op=001010: with MC_SLTI_EN, states 0,1,10,11 and aluop=11 in state 10; without it, 1->0 and illegal pulses once. op=111111 -> illegal pulses in both builds.
- rst_n pulled low during state 3 -> state=0 asynchronously, illegal=0, buserr=0. Resume fetch on release.

Source files
------------

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM with memory-ready watchdog.
// Optional slti support is compiled in when MC_SLTI_EN is defined.
module mc_main_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       illegal,
  output logic       buserr
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRtypeWb  = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StImmEx    = 4'd10,
    StImmWb    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
`ifdef MC_SLTI_EN
  localparam logic [5:0] OpSlti  = 6'b001010;
`endif

  localparam bit         WdogEn      = (TIMEOUT != 0);
  // Timeout fires on the cycle whose low memready would make the count reach TIMEOUT.
  localparam logic [7:0] TimeoutLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       buserr_q, buserr_d;
  logic       in_wait, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      wait_cnt_q <= 8'd0;
      illegal_q  <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      buserr_q   <= buserr_d;
    end
  end

  always_comb begin
    in_wait    = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    timeout    = WdogEn && in_wait && !memready && (wait_cnt_q == TimeoutLast);
    wait_cnt_d = (in_wait && !memready && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
    buserr_d   = timeout;
    illegal_d  = 1'b0;
    state_d    = state_q;

    case (state_q)
      StFetch:    if (memready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpRtype:     state_d = StExecute;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi:      state_d = StImmEx;
`ifdef MC_SLTI_EN
          OpSlti:      state_d = StImmEx;
`endif
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr:  state_d = (op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (memready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (memready) state_d = StFetch;
      StExecute:  state_d = StRtypeWb;
      StRtypeWb:  state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StImmEx:    state_d = StImmWb;
      StImmWb:    state_d = StFetch;
      default:    state_d = StFetch;
    endcase

    // A timeout in FETCH simply restarts the fetch.
    if (timeout) state_d = StFetch;
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop       = 2'b00;

    case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      StDecode:   alusrcb = 2'b11;
      StMemAddr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRead: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWrite: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StRtypeWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBranch: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      StJump: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      StImmEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
`ifdef MC_SLTI_EN
        aluop   = (op == OpSlti) ? 2'b11 : 2'b00;
`else
        aluop   = 2'b00;
`endif
      end
      StImmWb:    regwrite = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign buserr  = buserr_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control; two instances cover TIMEOUT=15 and TIMEOUT=4.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       memready = 1'b1;

  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal, buserr;
  logic [1:0] alusrcb, pcsource, aluop;
  logic [3:0] state;

  logic       pcwrite_4, pcwritecond_4, iord_4, memread_4, memwrite_4, irwrite_4;
  logic       memtoreg_4, regdst_4, regwrite_4, alusrca_4, illegal_4, buserr_4;
  logic [1:0] alusrcb_4, pcsource_4, aluop_4;
  logic [3:0] state_4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_main_control #(.TIMEOUT(15)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .memready(memready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop(aluop), .state(state), .illegal(illegal), .buserr(buserr)
  );

  mc_main_control #(.TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .memready(memready),
    .pcwrite(pcwrite_4), .pcwritecond(pcwritecond_4), .iord(iord_4), .memread(memread_4),
    .memwrite(memwrite_4), .irwrite(irwrite_4), .memtoreg(memtoreg_4), .regdst(regdst_4),
    .regwrite(regwrite_4), .alusrca(alusrca_4), .alusrcb(alusrcb_4), .pcsource(pcsource_4),
    .aluop(aluop_4), .state(state_4), .illegal(illegal_4), .buserr(buserr_4)
  );

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [5:0] new_op);
    rst_n    = 1'b0;
    op       = new_op;
    memready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    memready = 1'b1;
    tick();
    checks++; if (state !== 4'd0) begin errors++;
      $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({illegal, buserr} !== 2'b00) begin errors++;
      $display("FAIL reset_pulses: got %b want 00", {illegal, buserr}); end
    checks++; if ({memread, alusrcb, aluop} !== 5'b1_01_00) begin errors++;
      $display("FAIL reset_fetch_outs: got %b want 10100", {memread, alusrcb, aluop}); end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    do_reset(6'b000000);
    checks++; if ({state, irwrite, pcwrite} !== {4'd0, 2'b11}) begin errors++;
      $display("FAIL rtype_fetch: got %h want 03", {state, irwrite, pcwrite}); end
    tick();
    checks++; if ({state, alusrcb} !== {4'd1, 2'b11}) begin errors++;
      $display("FAIL rtype_decode: got %h want 7", {state, alusrcb}); end
    tick();
    checks++; if ({state, aluop, alusrca} !== {4'd6, 2'b10, 1'b1}) begin errors++;
      $display("FAIL rtype_execute: got %h want 35", {state, aluop, alusrca}); end
    tick();
    checks++; if ({state, regwrite, regdst} !== {4'd7, 2'b11}) begin errors++;
      $display("FAIL rtype_wb: got %h want 1f", {state, regwrite, regdst}); end
    tick();
    checks++; if (state !== 4'd0) begin errors++;
      $display("FAIL rtype_done: got %0d want 0", state); end
  endtask

  task automatic test_lw_wait();
    do_reset(6'b100011);
    tick();
    tick();
    checks++; if ({state, alusrca, alusrcb} !== {4'd2, 3'b110}) begin errors++;
      $display("FAIL lw_memaddr: got %h want 16", {state, alusrca, alusrcb}); end
    tick();
    memready = 1'b0;
    checks++; if ({state, memread, iord} !== {4'd3, 2'b11}) begin errors++;
      $display("FAIL lw_memread: got %h want 0f", {state, memread, iord}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({state, buserr} !== {4'd3, 1'b0}) begin errors++;
        $display("FAIL lw_hold%0d: got %h want 06", i, {state, buserr}); end
    end
    memready = 1'b1;
    tick();
    checks++; if ({state, memtoreg, regwrite, regdst, buserr} !== {4'd4, 4'b1100}) begin
      errors++;
      $display("FAIL lw_memwb: got %h want 4c", {state, memtoreg, regwrite, regdst, buserr}); end
    tick();
    checks++; if ({state, buserr} !== {4'd0, 1'b0}) begin errors++;
      $display("FAIL lw_done: got %h want 00", {state, buserr}); end
  endtask

  task automatic test_sw_timeout();
    do_reset(6'b101011);
    tick();
    tick();
    tick();
    memready = 1'b0;
    checks++; if ({state_4, memwrite_4, iord_4} !== {4'd5, 2'b11}) begin errors++;
      $display("FAIL sw_enter: got %h want 17", {state_4, memwrite_4, iord_4}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({state_4, memwrite_4, buserr_4} !== {4'd5, 2'b10}) begin errors++;
        $display("FAIL sw_hold%0d: got %h want 16", i, {state_4, memwrite_4, buserr_4}); end
    end
    tick();
    checks++; if ({state_4, buserr_4} !== {4'd0, 1'b1}) begin errors++;
      $display("FAIL sw_timeout: got %h want 01", {state_4, buserr_4}); end
    tick();
    checks++; if ({state_4, buserr_4} !== {4'd0, 1'b0}) begin errors++;
      $display("FAIL sw_buserr_width: got %h want 00", {state_4, buserr_4}); end
  endtask

  task automatic test_ready_wins();
    do_reset(6'b000000);
    memready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    memready = 1'b1;
    tick();
    checks++; if ({state_4, buserr_4} !== {4'd1, 1'b0}) begin errors++;
      $display("FAIL ready_wins: got %h want 02", {state_4, buserr_4}); end
    tick();
    checks++; if (buserr_4 !== 1'b0) begin errors++;
      $display("FAIL ready_wins_noerr: got %b want 0", buserr_4); end
  endtask

  task automatic test_branch_jump();
    do_reset(6'b000100);
    tick();
    tick();
    checks++; if ({state, pcwritecond, pcsource, aluop, alusrca} !== {4'd8, 6'b101011}) begin
      errors++;
      $display("FAIL beq_state: got %h want 22b", {state, pcwritecond, pcsource, aluop, alusrca});
    end
    tick();
    checks++; if (state !== 4'd0) begin errors++;
      $display("FAIL beq_done: got %0d want 0", state); end
    op = 6'b000010;
    tick();
    tick();
    checks++; if ({state, pcwrite, pcsource} !== {4'd9, 3'b110}) begin errors++;
      $display("FAIL j_state: got %h want 4e", {state, pcwrite, pcsource}); end
    tick();
    checks++; if (state !== 4'd0) begin errors++;
      $display("FAIL j_done: got %0d want 0", state); end
  endtask

  task automatic test_addi();
    do_reset(6'b001000);
    tick();
    tick();
    checks++; if ({state, alusrca, alusrcb, aluop} !== {4'd10, 5'b11000}) begin errors++;
      $display("FAIL addi_ex: got %h want 158", {state, alusrca, alusrcb, aluop}); end
    tick();
    checks++; if ({state, regwrite, regdst, memtoreg} !== {4'd11, 3'b100}) begin errors++;
      $display("FAIL addi_wb: got %h want 5c", {state, regwrite, regdst, memtoreg}); end
    tick();
    checks++; if (state !== 4'd0) begin errors++;
      $display("FAIL addi_done: got %0d want 0", state); end
  endtask

  task automatic test_slti_illegal();
    do_reset(6'b001010);
    tick();
    tick();
`ifdef MC_SLTI_EN
    checks++; if ({state, aluop, illegal} !== {4'd10, 3'b110}) begin errors++;
      $display("FAIL slti_ex: got %h want 56", {state, aluop, illegal}); end
    tick();
    checks++; if ({state, regwrite} !== {4'd11, 1'b1}) begin errors++;
      $display("FAIL slti_wb: got %h want 17", {state, regwrite}); end
`else
    checks++; if ({state, illegal} !== {4'd0, 1'b1}) begin errors++;
      $display("FAIL slti_illegal: got %h want 01", {state, illegal}); end
    tick();
    checks++; if ({state, illegal} !== {4'd1, 1'b0}) begin errors++;
      $display("FAIL slti_pulse_width: got %h want 02", {state, illegal}); end
`endif
    do_reset(6'b111111);
    tick();
    checks++; if ({state, illegal} !== {4'd1, 1'b0}) begin errors++;
      $display("FAIL bad_decode: got %h want 02", {state, illegal}); end
    tick();
    checks++; if ({state, illegal} !== {4'd0, 1'b1}) begin errors++;
      $display("FAIL bad_illegal: got %h want 01", {state, illegal}); end
    op = 6'b000000;
    tick();
    checks++; if (illegal !== 1'b0) begin errors++;
      $display("FAIL bad_pulse_width: got %b want 0", illegal); end
  endtask

  task automatic test_async_reset();
    do_reset(6'b100011);
    tick();
    tick();
    tick();
    memready = 1'b0;
    tick();
    checks++; if (state !== 4'd3) begin errors++;
      $display("FAIL areset_pre: got %0d want 3", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({state, illegal, buserr} !== {4'd0, 2'b00}) begin errors++;
      $display("FAIL areset_async: got %h want 00", {state, illegal, buserr}); end
    tick();
    memready = 1'b1;
    rst_n    = 1'b1;
    tick();
    checks++; if (state !== 4'd1) begin errors++;
      $display("FAIL areset_resume: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_timeout();
    test_ready_wins();
    test_branch_jump();
    test_addi();
    test_slti_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
